key_debounce_multi: RTL and testbench



---
 rtl/key_pkg.sv | 14 +
 rtl/key_debounce_chan.sv | 118 +++++++++++
 rtl/key_debounce_multi.sv | 38 +++
 tb/tb_key_debounce_multi.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared constants and helpers for the front-panel key debouncer.
package key_pkg;

  // Defaults sized for a 50 MHz system clock.
  localparam int unsigned DEB_CYCLES_50M = 1048575;
  localparam int unsigned LONG_50M       = 50000000;
  localparam int unsigned REPEAT_50M     = 10000000;

  // Pin level seen while the key is not pressed.
  function automatic logic released_level(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// Single key channel: two-flop synchroniser, stability counter, press/release pulses.
// Optional hold/auto-repeat counter when KEY_DEBOUNCE_REPEAT_EN is defined.
module key_debounce_chan
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEB_CYCLES_50M,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned LONG_CYCLES     = LONG_50M,
  parameter int unsigned REPEAT_CYCLES   = REPEAT_50M
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key,
  output logic o_key_state,
  output logic o_press,
  output logic o_release,
  output logic o_repeat
);

  localparam int unsigned     CntW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_param_check
    $error("key_debounce_chan: cycle parameters out of range");
  end

  logic            sync1_q, sync2_q;
  logic            sample;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            state_q, state_d;
  logic            press_q, press_d;
  logic            release_q, release_d;

  always_comb begin
    sample    = sync2_q ^ ACTIVE_LOW;
    cnt_d     = cnt_q;
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sample == state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      state_d   = sample;
      cnt_d     = '0;
      press_d   = sample;
      release_d = ~sample;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q   <= released_level(ACTIVE_LOW);
      sync2_q   <= released_level(ACTIVE_LOW);
      cnt_q     <= '0;
      state_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= i_key;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign o_key_state = state_q;
  assign o_press     = press_q;
  assign o_release   = release_q;

`ifdef KEY_DEBOUNCE_REPEAT_EN
  localparam int unsigned HoldMax = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int unsigned HoldW   = (HoldMax > 2) ? $clog2(HoldMax) : 1;
  localparam logic [HoldW-1:0] LongMax = HoldW'(LONG_CYCLES - 1);
  localparam logic [HoldW-1:0] RepMax  = HoldW'(REPEAT_CYCLES - 1);

  logic [HoldW-1:0] hold_q, hold_d;
  logic             first_q, first_d;
  logic             repeat_q, repeat_d;

  // first_q selects the long initial hold versus the shorter repeat period.
  always_comb begin
    hold_d   = hold_q;
    first_d  = first_q;
    repeat_d = 1'b0;
    if (press_d || !state_q || release_d) begin
      hold_d  = '0;
      first_d = 1'b1;
    end else if ((first_q && hold_q == LongMax) || (!first_q && hold_q == RepMax)) begin
      repeat_d = 1'b1;
      hold_d   = '0;
      first_d  = 1'b0;
    end else begin
      hold_d = hold_q + HoldW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hold_q   <= '0;
      first_q  <= 1'b1;
      repeat_q <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      first_q  <= first_d;
      repeat_q <= repeat_d;
    end
  end

  assign o_repeat = repeat_q;
`else
  assign o_repeat = 1'b0;
`endif

endmodule

// File: rtl/key_debounce_multi.sv
// N-channel push-button debouncer; outputs normalised to pressed = 1.
// Auto-repeat is built only when KEY_DEBOUNCE_REPEAT_EN is defined.
module key_debounce_multi
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEB_CYCLES_50M,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned LONG_CYCLES     = LONG_50M,
  parameter int unsigned REPEAT_CYCLES   = REPEAT_50M
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_KEYS-1:0] i_key,
  output logic [N_KEYS-1:0] o_key_state,
  output logic [N_KEYS-1:0] o_press,
  output logic [N_KEYS-1:0] o_release,
  output logic [N_KEYS-1:0] o_repeat
);

  for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
    key_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW),
      .LONG_CYCLES    (LONG_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_chan (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_key      (i_key[g]),
      .o_key_state(o_key_state[g]),
      .o_press    (o_press[g]),
      .o_release  (o_release[g]),
      .o_repeat   (o_repeat[g])
    );
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Scoreboard bench for key_debounce_multi: expected pulse events queued by stimulus, checked by monitor.
module tb_key_debounce_multi;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [3:0] i_key = 4'hF;
  logic [3:0] o_key_state, o_press, o_release, o_repeat;

  key_debounce_multi #(
    .N_KEYS         (4),
    .DEBOUNCE_CYCLES(8),
    .ACTIVE_LOW     (1'b1),
    .LONG_CYCLES    (20),
    .REPEAT_CYCLES  (5)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_key      (i_key),
    .o_key_state(o_key_state),
    .o_press    (o_press),
    .o_release  (o_release),
    .o_repeat   (o_repeat)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] rpt;
    logic [3:0] state;
  } ev_t;

  ev_t exp_q[$];
  int  cyc      = 0;
  int  checks   = 0;
  int  failures = 0;
  bit  mon_en   = 1'b0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int c, input logic [3:0] p, input logic [3:0] r,
                         input logic [3:0] rp, input logic [3:0] st);
    ev_t e;
    e.cyc = c; e.press = p; e.rel = r; e.rpt = rp; e.state = st;
    exp_q.push_back(e);
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // Monitor: every pulse cycle must match the next queued event.
  always @(negedge i_clk) begin
    if (mon_en && ((o_press | o_release | o_repeat) !== 4'h0)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", int'({o_press, o_release, o_repeat}), 0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("event_cycle", cyc, e.cyc);
        chk("o_press", int'(o_press), int'(e.press));
        chk("o_release", int'(o_release), int'(e.rel));
        chk("o_repeat", int'(o_repeat), int'(e.rpt));
        chk("o_key_state", int'(o_key_state), int'(e.state));
      end
    end
  end

  initial begin
    int t;
    // Reset state
    wait_edges(3);
    chk("reset_key_state", int'(o_key_state), 0);
    chk("reset_press", int'(o_press), 0);
    chk("reset_release", int'(o_release), 0);
    chk("reset_repeat", int'(o_repeat), 0);
    i_rst  = 1'b0;
    mon_en = 1'b1;
    wait_edges(2);

    // Clean press and release on key 0
    i_key[0] = 1'b0; t = cyc;
    push_ev(t + 10, 4'h1, 4'h0, 4'h0, 4'h1);
    wait_edges(15);
    i_key[0] = 1'b1; t = cyc;
    push_ev(t + 10, 4'h0, 4'h1, 4'h0, 4'h0);
    wait_edges(15);

    // Bouncing press on key 1: low 3, high 1, low 5, high 1, then held low
    t = cyc;
    push_ev(t + 20, 4'h2, 4'h0, 4'h0, 4'h2);
    i_key[1] = 1'b0; wait_edges(3);
    i_key[1] = 1'b1; wait_edges(1);
    i_key[1] = 1'b0; wait_edges(5);
    i_key[1] = 1'b1; wait_edges(1);
    i_key[1] = 1'b0; wait_edges(15);
    i_key[1] = 1'b1; t = cyc;
    push_ev(t + 10, 4'h0, 4'h2, 4'h0, 4'h0);
    wait_edges(15);
    chk("idle_after_bounce", exp_q.size(), 0);

    // All keys on the same edge
    i_key = 4'h0; t = cyc;
    push_ev(t + 10, 4'hF, 4'h0, 4'h0, 4'hF);
    wait_edges(15);
    i_key = 4'hF; t = cyc;
    push_ev(t + 10, 4'h0, 4'hF, 4'h0, 4'h0);
    wait_edges(15);

    // Reset five cycles into a debounce: nothing may follow
    i_key[3] = 1'b0;
    wait_edges(5);
    i_rst = 1'b1; i_key[3] = 1'b1;
    wait_edges(1);
    i_rst = 1'b0;
    wait_edges(20);
    chk("abort_key_state", int'(o_key_state), 0);
    chk("abort_queue_empty", exp_q.size(), 0);

    // Held key 2; release lands on a due repeat cycle
    i_key[2] = 1'b0; t = cyc;
    push_ev(t + 10, 4'h4, 4'h0, 4'h0, 4'h4);
`ifdef KEY_DEBOUNCE_REPEAT_EN
    push_ev(t + 30, 4'h0, 4'h0, 4'h4, 4'h4);
    push_ev(t + 35, 4'h0, 4'h0, 4'h4, 4'h4);
    push_ev(t + 40, 4'h0, 4'h0, 4'h4, 4'h4);
`endif
    wait_edges(35);
    i_key[2] = 1'b1; t = cyc;
    push_ev(t + 10, 4'h0, 4'h4, 4'h0, 4'h0);
    wait_edges(25);

    chk("final_key_state", int'(o_key_state), 0);
    while (exp_q.size() != 0) begin
      ev_t e;
      e = exp_q.pop_front();
      chk("missing_event_at_cycle", e.cyc, -1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
